demux_2_target: RTL and testbench
=================================

# demux_2_target

Registered 1-to-2 demultiplexer for the 24-bit datapath: accepts one word per handshake from a single source and delivers it to exactly one of two destinations selected by a per-word select bit. It is the distributing counterpart of the registered 2-choice mux, placed where one producer (e.g. ALU result or memory read data) must be steered to one of two consumers. A single holding register with valid/ready handshakes on all sides provides full throughput, and per-target wrapping counters record delivered words.

## Interface
- WIDTH, 24, data word width in bits.
- CNT_W, 16, width of each per-target delivery counter.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  WIDTH  word offered by the source.
- in_sel  input  1  target for in_data; 0 selects target 0, 1 selects target 1.
- in_valid  input  1  source offers in_data/in_sel this cycle.
- in_ready  output  1  block accepts the offered word this cycle.
- out0_data  output  WIDTH  holding-register contents.
- out0_valid  output  1  holding register holds a word for target 0.
- out0_ready  input  1  target 0 takes the word this cycle.
- out1_data  output  WIDTH  holding-register contents; identical to out0_data.
- out1_valid  output  1  holding register holds a word for target 1.
- out1_ready  input  1  target 1 takes the word this cycle.
- out0_count  output  CNT_W  number of words delivered to target 0, modulo 2^CNT_W.
- out1_count  output  CNT_W  number of words delivered to target 1, modulo 2^CNT_W.

## Operation
- State machine with three states: EMPTY, FULL0, FULL1. The holding register is `hold`, WIDTH bits wide.
- out0_valid = (state == FULL0). out1_valid = (state == FULL1). Both are decoded from registered state.
- out0_data and out1_data are both driven by `hold`. Only the matching valid qualifies the data.
- Input acceptance: in_ready = EMPTY | (FULL0 & out0_ready) | (FULL1 & out1_ready). This makes in_ready combinational on outx_ready, but it does not depend on in_sel or in_valid.
- accept = in_valid & in_ready.
- drain = (FULL0 & out0_ready) | (FULL1 & out1_ready).
- Transitions on each clk edge:
  - EMPTY, no accept: stay in EMPTY.
  - EMPTY, accept: `hold` <= in_data; go to FULL0 if in_sel = 0, FULL1 if in_sel = 1.
  - FULLx, no drain: hold state and `hold`. New input is refused because in_ready = 0.
  - FULLx, drain, no accept: go to EMPTY; `hold` keeps its stale value.
  - FULLx, drain and accept in the same cycle: `hold` <= in_data; next state is chosen by in_sel, so it may switch target. There is no bubble.
- outx_ready asserted while outx_valid = 0 has no effect and does not change the counters.
- The ready input of the non-selected target is ignored.
- Counters:
  - outx_count increments by 1 on each cycle where outx_valid & outx_ready is true.
  - Counters wrap from 2^CNT_W−1 to 0 with no flag.
  - Only one counter can increment in any cycle.
- Words are never duplicated, dropped, or reordered. Every accepted word is delivered exactly once to its selected target.

## Timing
- Reset (asynchronous, rst = 1) immediately forces:
  - state = EMPTY, `hold` = 0, out0_count = out1_count = 0;
  - therefore out0_valid = out1_valid = 0, out0_data = out1_data = 0, and in_ready = 1.
- Reset asserted mid-operation discards any held word without delivering it.
- First accept is possible on the first rising edge after rst deasserts.
- Latency: a word accepted at edge N is presented with outx_valid = 1 from just after edge N. If outx_ready is high in the following cycle, it is consumed at edge N+1.
- Throughput: one word per cycle when the selected target keeps its ready high, including alternating targets.
- A target stalling (outx_ready = 0) back-pressures the source regardless of the next word's in_sel. There is no head-of-line bypass.
- The source must hold in_data and in_sel stable while in_valid = 1 and in_ready = 0. The block samples them only on accept.

## Test plan
- Reset: assert rst mid-cycle while in FULL1 holding 24'hABCDEF. Required: out1_valid drops immediately; outputs read 0; counts read 0; in_ready = 1; the word is never delivered.
- Single transfer: offer in_data = 24'h123456 with in_sel = 0, then out0_ready = 1 for one cycle. Required: out0_valid for exactly 1 cycle with data 24'h123456; out1_valid stays 0; out0_count = 1.
- Back-to-back alternating: stream 24'h000001, 24'h000002, 24'h000003, 24'h000004 with in_sel = 0, 1, 0, 1 and both readies held at 1. Required:
  - one word delivered per cycle, no bubbles;
  - target 0 receives 1 then 3; target 1 receives 2 then 4;
  - final out0_count = out1_count = 2.
- Back-pressure: hold 24'h00BEEF for target 1 with out1_ready = 0 for 5 cycles while out0_ready = 1 and the source offers an in_sel = 0 word. Required:
  - in_ready = 0 for all 5 cycles;
  - out0_valid = 0 throughout;
  - after out1_ready rises, 24'h00BEEF is delivered and the pending word is accepted in the same cycle.
- Spurious ready: in EMPTY, pulse out0_ready and out1_ready for 3 cycles. Required: no valid asserted and counts unchanged.
- Counter wrap: with CNT_W = 4, deliver 17 words to target 0. Required: out0_count reads 15 after word 15, 0 after word 16, 1 after word 17; out1_count stays 0.

Source files
------------

// File: rtl/demux_2_target.sv
// rtl/demux_2_target.sv - registered 1-to-2 demultiplexer with per-target delivery counters

module demux_2_target #(
  parameter int WIDTH = 24,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [CNT_W-1:0] out0_count,
  output logic [CNT_W-1:0] out1_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL0 = 2'd1,
    FULL1 = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   hold_q, hold_d;
  logic [CNT_W-1:0]   cnt0_q, cnt0_d;
  logic [CNT_W-1:0]   cnt1_q, cnt1_d;

  logic fire0;
  logic fire1;
  logic drain;
  logic accept;

  // Handshake decode: a slot frees up when empty or when its current owner takes the word,
  // so a new word can enter on the same edge the old one leaves.
  always_comb begin
    out0_valid = (state_q == FULL0);
    out1_valid = (state_q == FULL1);
    fire0      = out0_valid & out0_ready;
    fire1      = out1_valid & out1_ready;
    drain      = fire0 | fire1;
    in_ready   = (state_q == EMPTY) | drain;
    accept     = in_valid & in_ready;
  end

  // Next-state and holding-register update; the new target comes from in_sel on every accept.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    if (accept) begin
      hold_d  = in_data;
      state_d = in_sel ? FULL1 : FULL0;
    end else if (drain) begin
      state_d = EMPTY;
    end
  end

  // Delivery counters wrap silently; at most one fires per cycle since only one valid is up.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (fire0) begin
      cnt0_d = cnt0_q + 1'b1;
    end
    if (fire1) begin
      cnt1_d = cnt1_q + 1'b1;
    end
  end

  // State, holding register and counters; reset discards any held word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      hold_q  <= '0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  assign out0_data  = hold_q;
  assign out1_data  = hold_q;
  assign out0_count = cnt0_q;
  assign out1_count = cnt1_q;

endmodule

// File: tb/tb_demux_2_target.sv
// tb/tb_demux_2_target.sv - self-checking bench for demux_2_target

module tb_demux_2_target;

  localparam int WIDTH = 24;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out1_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [CNT_W-1:0] out0_count;
  logic [CNT_W-1:0] out1_count;

  demux_2_target #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out0_count (out0_count),
    .out1_count (out1_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] din;
    logic             sel;
    logic             vld;
    logic             r0;
    logic             r1;
    logic             rdy;
    logic             v0;
    logic             v1;
    logic [WIDTH-1:0] data;
    logic [CNT_W-1:0] c0;
    logic [CNT_W-1:0] c1;
  } vec_t;

  int n_checks;
  int n_pass;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [WIDTH-1:0] d, input logic s, input logic v,
                       input logic r0, input logic r1);
    in_data    = d;
    in_sel     = s;
    in_valid   = v;
    out0_ready = r0;
    out1_ready = r1;
  endtask

  task automatic check_all(input string tag, input logic rdy, input logic v0, input logic v1,
                           input logic [WIDTH-1:0] data, input logic [CNT_W-1:0] c0,
                           input logic [CNT_W-1:0] c1);
    check({tag, ".in_ready"},   32'(in_ready),   32'(rdy));
    check({tag, ".out0_valid"}, 32'(out0_valid), 32'(v0));
    check({tag, ".out1_valid"}, 32'(out1_valid), 32'(v1));
    check({tag, ".out0_data"},  32'(out0_data),  32'(data));
    check({tag, ".out1_data"},  32'(out1_data),  32'(data));
    check({tag, ".out0_count"}, 32'(out0_count), 32'(c0));
    check({tag, ".out1_count"}, 32'(out1_count), 32'(c1));
  endtask

  vec_t vecs[11];

  initial begin
    n_checks = 0;
    n_pass   = 0;

    // Each row: inputs for one cycle, then outputs expected during that cycle (before its edge).
    //             din        sel   vld   r0    r1    rdy   v0    v1    data       c0    c1
    vecs[0]  = '{24'h123456, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000000, 4'd0, 4'd0};
    vecs[1]  = '{24'h000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 24'h123456, 4'd0, 4'd0};
    vecs[2]  = '{24'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h123456, 4'd1, 4'd0};
    vecs[3]  = '{24'h000001, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 24'h123456, 4'd1, 4'd0};
    vecs[4]  = '{24'h000002, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 24'h000001, 4'd1, 4'd0};
    vecs[5]  = '{24'h000003, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 24'h000002, 4'd2, 4'd0};
    vecs[6]  = '{24'h000004, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 24'h000003, 4'd2, 4'd1};
    vecs[7]  = '{24'h000000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 24'h000004, 4'd3, 4'd1};
    vecs[8]  = '{24'h000000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 24'h000004, 4'd3, 4'd2};
    vecs[9]  = '{24'h000000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 24'h000004, 4'd3, 4'd2};
    vecs[10] = '{24'h000000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 24'h000004, 4'd3, 4'd2};

    rst = 1'b1;
    drive(24'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check_all("reset0", 1'b1, 1'b0, 1'b0, 24'h0, 4'd0, 4'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single transfer, alternating stream, spurious readies
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].din, vecs[i].sel, vecs[i].vld, vecs[i].r0, vecs[i].r1);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].v0, vecs[i].v1,
                vecs[i].data, vecs[i].c0, vecs[i].c1);
      @(negedge clk);
    end

    // Back-pressure: target 1 stalls while a target-0 word waits at the source
    drive(24'h00BEEF, 1'b1, 1'b1, 1'b1, 1'b0);
    #1;
    check("bp.load_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    drive(24'h0000AA, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("bp.stall%0d.in_ready", i), 32'(in_ready), 32'd0);
      check($sformatf("bp.stall%0d.out0_valid", i), 32'(out0_valid), 32'd0);
      check($sformatf("bp.stall%0d.out1_valid", i), 32'(out1_valid), 32'd1);
      check($sformatf("bp.stall%0d.data", i), 32'(out1_data), 32'h00BEEF);
      @(negedge clk);
    end
    out1_ready = 1'b1;
    #1;
    check_all("bp.release", 1'b1, 1'b0, 1'b1, 24'h00BEEF, 4'd3, 4'd2);
    @(negedge clk);
    drive(24'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    #1;
    check_all("bp.pending", 1'b1, 1'b1, 1'b0, 24'h0000AA, 4'd3, 4'd3);
    @(negedge clk);
    #1;
    check_all("bp.done", 1'b1, 1'b0, 1'b0, 24'h0000AA, 4'd4, 4'd3);

    // Asynchronous reset while FULL1 holds a word
    @(negedge clk);
    drive(24'hABCDEF, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    drive(24'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check("rst.pre_valid", 32'(out1_valid), 32'd1);
    check("rst.pre_data", 32'(out1_data), 32'hABCDEF);
    #1;
    rst = 1'b1;
    #1;
    check_all("rst.mid", 1'b1, 1'b0, 1'b0, 24'h0, 4'd0, 4'd0);
    @(negedge clk);
    rst = 1'b0;
    out1_ready = 1'b1;
    @(negedge clk);
    #1;
    check_all("rst.after", 1'b1, 1'b0, 1'b0, 24'h0, 4'd0, 4'd0);

    // Counter wrap on target 0 with a 4-bit counter
    for (int n = 1; n <= 17; n++) begin
      @(negedge clk);
      drive(24'(n), 1'b0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      drive(24'h0, 1'b0, 1'b0, 1'b1, 1'b0);
      #1;
      check($sformatf("wrap%0d.valid", n), 32'(out0_valid), 32'd1);
      check($sformatf("wrap%0d.data", n), 32'(out0_data), 32'(n));
      @(negedge clk);
      out0_ready = 1'b0;
      #1;
      check($sformatf("wrap%0d.count0", n), 32'(out0_count), 32'(n % 16));
      check($sformatf("wrap%0d.count1", n), 32'(out1_count), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
